branch_redirect_unit: RTL
=========================

// Module: branch_redirect_unit
// PURPOSE
//  - Decode-side consumer of the 24-bit fetch bundle {instr[15:0], pc[7:0]}.
//  - Latches each bundle into an IF/ID register and resolves JMP/BZ/BNZ.
//  - Drives the 9-bit {is_branch, target[7:0]} redirect back to fetch.
//  - Squashes wrong-path instructions fetched before the redirect takes effect; feeds the decode/execute stage.
// PARAMETERS
//  - PC_W     8   pc / branch target width
//  - INSTR_W  16  instruction width; opcode = instr[INSTR_W-1 -: 4], target = instr[PC_W-1:0]
// PORTS
//  - clk                          in   1        rising-edge clock, sole clock domain
//  - rst_n                        in   1        asynchronous active-low reset
//  - IF_output                    in   24       fetch bundle: [23:8] instr, [7:0] pc; new each cycle, no stall
//  - cond_zero                    in   1        execute-stage zero flag, sampled in cycle branch sits in ID
//  - Branch_Update_with_isBranch  out  9        [8] is_branch, [7:0] target; fetch samples at posedge
//  - id_valid                     out  1        ID register holds a non-squashed instruction
//  - id_pc                        out  PC_W     pc of ID instruction
//  - id_instr                     out  INSTR_W  ID instruction
// BEHAVIOUR
//  - Reset (async assert, sync deassert at next edge):
//    - id_valid=0, id_pc=0, id_instr=0
//    - Branch_Update_with_isBranch=9'h000
//    - state=RUN
//  - ID register loads IF_output on every posedge; there is no stall path.
//  - Taken = id_valid & state==RUN & (opc==JMP | opc==BZ&cond_zero | opc==BNZ&~cond_zero).
//  - Default (registered) redirect, branch at pc b in ID during cycle T:
//    - Edge E1: redirect reg <= {1,target}, ID <= b+1, state RUN->SQ1.
//    - Cycle T+1: redirect visible. Edge E2: fetch pc <= target; ID <= b+2; redirect reg <= 0; SQ1->SQ2.
//    - Edge E3: ID <= target instruction, state SQ2->RUN.
//    - id_valid=0 while ID holds b+1 and b+2 (two squash slots).
//  - Redirect is a one-cycle pulse; never asserted on consecutive cycles.
//  - Outside a pulse, bits [7:0] are 0.
//  - Branch instructions in squashed slots are ignored: no redirect, state unchanged.
//  - Self-loop (target==b) legal; repeats the sequence every 3 cycles.
//  - Target arithmetic: 8-bit, no offset.
//  - pc wrap 8'hFF->8'h00 is not special; a wrapped fetch is still squashed by slot count.
//  - Non-branch opcodes pass through with id_valid=1 in RUN.
//  - Reset mid-squash: redirect cleared immediately, state RUN.
//    - First post-reset latch is valid (fetch pc is not reset by this block).
//  - FSM: RUN, SQ1, SQ2 (2-bit encoding); SQ1/SQ2 unconditionally advance.
// CONFIGURATION
//  - BRU_FAST_REDIRECT_EN defined: redirect driven combinationally from ID/taken in cycle T.
//    - Fetch pc <= target at E1; ID(b+1) squashed.
//    - Target latched at E2.
//    - FSM uses RUN, SQ1 only (SQ1->RUN).
//  - Undefined: registered redirect, two squash slots, as above.
// STRUCTURE
//  - Package bru_pkg: OPC_JMP=4'hC, OPC_BZ=4'hD, OPC_BNZ=4'hE; state typedef/localparams.
//  - Sub-module branch_decoder (comb): instr, cond_zero -> is_branch_op, taken_raw, target.
//  - Top: ID register, FSM, redirect register/mux.
// TESTING
//  - Straight-line: ALU instrs at pc 0..3 -> id_valid=1 each cycle, id_pc=0,1,2,3; redirect 9'h000 throughout.
//  - JMP 0x04 at pc 1 -> redirect 9'h104 for exactly one cycle.
//    - ID pcs 2,3 have id_valid=0; next valid id_pc=4.
//    - FAST_EN: only pc 2 squashed.
//  - BZ 0x10 at pc 5 with cond_zero=0 -> no redirect, pc 6 valid.
//    - Repeat with cond_zero=1 -> redirect 9'h110.
//  - JMP in squash slot (pc 2 = JMP 0x20 after JMP 0x04 at pc 1) -> single redirect 9'h104 only; id_pc 4 valid.
//  - Reset: rst_n low during SQ1 -> outputs zero same cycle; after release, next latched instr id_valid=1.
//  - Self-loop JMP 0x07 at pc 7 -> redirect 9'h107 every 3rd cycle (2nd with FAST_EN); never back-to-back.

Source files
------------

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared opcodes and FSM state encodings for the branch redirect unit
package bru_pkg;

  localparam logic [3:0] OPC_JMP = 4'hC;
  localparam logic [3:0] OPC_BZ  = 4'hD;
  localparam logic [3:0] OPC_BNZ = 4'hE;

  typedef logic [1:0] bru_state_t;

  localparam bru_state_t ST_RUN = 2'd0;
  localparam bru_state_t ST_SQ1 = 2'd1;
  localparam bru_state_t ST_SQ2 = 2'd2;

endpackage

// File: rtl/branch_decoder.sv
// rtl/branch_decoder.sv - combinational JMP/BZ/BNZ decode and condition resolution
module branch_decoder
  import bru_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               cond_zero,
  output logic               is_branch_op,
  output logic               taken_raw,
  output logic [PC_W-1:0]    target
);

  logic [3:0] opc;

  assign opc    = instr[INSTR_W-1 -: 4];
  assign target = instr[PC_W-1:0];

  always_comb begin
    is_branch_op = 1'b0;
    taken_raw    = 1'b0;
    case (opc)
      OPC_JMP: begin
        is_branch_op = 1'b1;
        taken_raw    = 1'b1;
      end
      OPC_BZ: begin
        is_branch_op = 1'b1;
        taken_raw    = cond_zero;
      end
      OPC_BNZ: begin
        is_branch_op = 1'b1;
        taken_raw    = ~cond_zero;
      end
      default: begin
        is_branch_op = 1'b0;
        taken_raw    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - IF/ID register, squash FSM and redirect to fetch; option BRU_FAST_REDIRECT_EN
module branch_redirect_unit
  import bru_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INSTR_W+PC_W-1:0] IF_output,
  input  logic                    cond_zero,
  output logic [PC_W:0]           Branch_Update_with_isBranch,
  output logic                    id_valid,
  output logic [PC_W-1:0]         id_pc,
  output logic [INSTR_W-1:0]      id_instr
);

  bru_state_t          state;
  bru_state_t          state_next;
  logic                is_branch_op;
  logic                taken_raw;
  logic                taken;
  logic [PC_W-1:0]     target;

  branch_decoder #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_decoder (
    .instr        (id_instr),
    .cond_zero    (cond_zero),
    .is_branch_op (is_branch_op),
    .taken_raw    (taken_raw),
    .target       (target)
  );

  // Only a live instruction in RUN may redirect; branches in squash slots are inert.
  assign taken = id_valid & (state == ST_RUN) & is_branch_op & taken_raw;

  always_comb begin
    state_next = ST_RUN;
    case (state)
      ST_RUN: state_next = taken ? ST_SQ1 : ST_RUN;
`ifdef BRU_FAST_REDIRECT_EN
      ST_SQ1: state_next = ST_RUN;
`else
      ST_SQ1: state_next = ST_SQ2;
      ST_SQ2: state_next = ST_RUN;
`endif
      default: state_next = ST_RUN;
    endcase
  end

  // The ID slot is live exactly when the FSM is back in RUN after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= '0;
    end else begin
      state    <= state_next;
      id_valid <= (state_next == ST_RUN);
      id_pc    <= IF_output[PC_W-1:0];
      id_instr <= IF_output[INSTR_W+PC_W-1:PC_W];
    end
  end

`ifdef BRU_FAST_REDIRECT_EN
  assign Branch_Update_with_isBranch = taken ? {1'b1, target} : '0;
`else
  logic [PC_W:0] redirect_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q <= '0;
    end else begin
      redirect_q <= taken ? {1'b1, target} : '0;
    end
  end

  assign Branch_Update_with_isBranch = redirect_q;
`endif

endmodule
